// File: rtl/multiplier.sv
// Sequential 32x32 multiplier: radix-2 Booth (signed) with an optional unsigned shift-add mode,
// fixed 33-cycle latency. Define MULT_UNSIGNED_EN to add the mult_unsigned mode-select port.
module multiplier (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
`ifdef MULT_UNSIGNED_EN
  input  logic        mult_unsigned,
`endif
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic [1:0]  fsm_state
);

  // Handshake: start is sampled on every rising edge while in IDLE or FIN.
  // An edge with start=1 in either state is the accepting edge. a, b and the mode are
  // captured on that edge only. busy stays high from the next cycle through FIN.
  // done is high for the single FIN cycle, during which hi/lo already carry the new product.
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIN  = 2'd2;

  logic [1:0]  state;
  logic [32:0] acc;
  logic [31:0] m;
  logic [31:0] q;
  logic        qm1;
  logic [5:0]  count;
  logic        uns_sel;
  logic        accept;

  logic [32:0] sum;
  logic [32:0] nxt_acc;
  logic [31:0] nxt_q;
  logic        nxt_qm1;

`ifdef MULT_UNSIGNED_EN
  logic uns_mode;
  assign uns_sel = uns_mode;
`else
  assign uns_sel = 1'b0;
`endif

  assign accept    = start && ((state == IDLE) || (state == FIN));
  assign busy      = (state != IDLE);
  assign done      = (state == FIN);
  assign fsm_state = state;

  // One multiply step. The 33-bit accumulator keeps -2^31 * -2^31 from overflowing.
  always_comb begin
    sum     = acc;
    nxt_acc = acc;
    if (uns_sel) begin
      if (q[0]) begin
        sum = acc + {1'b0, m};
      end
      nxt_acc = {1'b0, sum[32:1]};
    end else begin
      case ({q[0], qm1})
        2'b01:   sum = acc + {m[31], m};
        2'b10:   sum = acc - {m[31], m};
        default: sum = acc;
      endcase
      nxt_acc = {sum[32], sum[32:1]};
    end
    nxt_q   = {sum[0], q[31:1]};
    nxt_qm1 = q[0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      acc   <= '0;
      m     <= '0;
      q     <= '0;
      qm1   <= 1'b0;
      count <= '0;
      hi    <= '0;
      lo    <= '0;
`ifdef MULT_UNSIGNED_EN
      uns_mode <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, FIN: begin
          if (accept) begin
            state <= RUN;
            m     <= a;
            q     <= b;
            acc   <= '0;
            qm1   <= 1'b0;
            count <= '0;
`ifdef MULT_UNSIGNED_EN
            uns_mode <= mult_unsigned;
`endif
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          // Counts 0..31 perform the 32 steps; the terminal cycle at 32 publishes the product.
          if (count == 6'd32) begin
            hi    <= acc[31:0];
            lo    <= q;
            state <= FIN;
          end else begin
            acc   <= nxt_acc;
            q     <= nxt_q;
            qm1   <= nxt_qm1;
            count <= count + 6'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multiplier.sv
// Directed self-checking bench for multiplier: latency, signed/unsigned products,
// start-while-busy, back-to-back requests, reset behaviour.
module tb_multiplier;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        mult_unsigned;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic [1:0]  fsm_state;

  int checks   = 0;
  int failures = 0;

  multiplier dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .a             (a),
    .b             (b),
`ifdef MULT_UNSIGNED_EN
    .mult_unsigned (mult_unsigned),
`endif
    .hi            (hi),
    .lo            (lo),
    .busy          (busy),
    .done          (done),
    .fsm_state     (fsm_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advances until done is seen or the cycle budget runs out; lat counts edges since acceptance.
  task automatic wait_done(input int start_n, output int lat);
    lat = start_n;
    while (done !== 1'b1 && lat < 100) begin
      tick;
      lat++;
    end
  endtask

  // Presents operands for one accepting edge, then scrambles them to prove single capture.
  task automatic launch(input logic [31:0] x, input logic [31:0] y, input logic u);
    a = x;
    b = y;
    mult_unsigned = u;
    start = 1'b1;
    tick;
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    mult_unsigned = ~u;
  endtask

  task automatic op(input string tag, input logic [31:0] x, input logic [31:0] y, input logic u,
                    input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int lat;
    launch(x, y, u);
    check({tag, "_busy_run"}, busy, 1'b1);
    wait_done(0, lat);
    check({tag, "_latency"}, lat, 33);
    check({tag, "_hi"}, hi, exp_hi);
    check({tag, "_lo"}, lo, exp_lo);
    check({tag, "_busy_fin"}, busy, 1'b1);
    tick;
    check({tag, "_done_drop"}, done, 1'b0);
    check({tag, "_busy_idle"}, busy, 1'b0);
  endtask

  initial begin
    int lat;
    int seen_done;
    reset_n = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    mult_unsigned = 1'b0;

    // Asynchronous reset before any clock edge.
    #2 reset_n = 1'b0;
    #1;
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_state", fsm_state, 2'd0);
    tick;
    tick;
    reset_n = 1'b1;
    tick;
    tick;
    check("idle_busy", busy, 1'b0);

    op("mul_7x6", 32'd7, 32'd6, 1'b0, 32'h0000_0000, 32'h0000_002A);

    // Second request at cycle 10 is ignored; hi/lo keep the previous result during RUN.
    launch(32'd2, 32'd3, 1'b0);
    repeat (9) tick;
    check("ign_hold_lo", lo, 32'h0000_002A);
    a = 32'd9;
    b = 32'd9;
    start = 1'b1;
    tick;
    start = 1'b0;
    check("ign_busy", busy, 1'b1);
    wait_done(10, lat);
    check("ign_latency", lat, 33);
    check("ign_lo", lo, 32'd6);
    check("ign_hi", hi, 32'd0);
    tick;

    op("mul_neg3x5", 32'hFFFF_FFFD, 32'd5, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    op("mul_min_sq", 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h4000_0000, 32'h0000_0000);
    op("mul_zero", 32'd0, 32'd0, 1'b0, 32'h0, 32'h0);
    op("mul_m1_sq", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h0, 32'h1);
    op("mul_neg_pos", 32'h7FFF_FFFF, 32'hFFFF_FFFE, 1'b0, 32'hFFFF_FFFF, 32'h0000_0002);

    // Back-to-back: start held through FIN is accepted on the edge leaving FIN.
    a = 32'd3;
    b = 32'd4;
    start = 1'b1;
    tick;
    wait_done(0, lat);
    check("b2b_first_latency", lat, 33);
    check("b2b_first_lo", lo, 32'd12);
    a = 32'd5;
    b = 32'd5;
    tick;
    start = 1'b0;
    a = '0;
    b = '0;
    check("b2b_accept_busy", busy, 1'b1);
    check("b2b_hold_lo", lo, 32'd12);
    wait_done(0, lat);
    check("b2b_second_latency", lat, 33);
    check("b2b_second_lo", lo, 32'd25);
    tick;

    // Reset mid-operation aborts immediately and no done follows.
    launch(32'd7, 32'd6, 1'b0);
    repeat (14) tick;
    #2 reset_n = 1'b0;
    #1;
    check("abort_hi", hi, 32'h0);
    check("abort_lo", lo, 32'h0);
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    tick;
    reset_n = 1'b1;
    seen_done = 0;
    for (int i = 0; i < 40; i++) begin
      tick;
      if (done === 1'b1) seen_done++;
    end
    check("abort_no_done", seen_done, 0);
    check("abort_state", fsm_state, 2'd0);

    op("post_reset", 32'd11, 32'd13, 1'b0, 32'h0, 32'd143);

`ifdef MULT_UNSIGNED_EN
    op("uns_max_sq", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE, 32'h0000_0001);
    op("sgn_max_sq", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 32'h0000_0001);
    op("uns_big", 32'h8000_0000, 32'd2, 1'b1, 32'h0000_0001, 32'h0000_0000);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
